// File: rtl/ex_mem_stage_pkg.sv
// ============================================================================
//  Module  : ex_mem_stage_pkg
//  Purpose : Shared constants, ALU op encodings, writeback-select encodings
//            and FSM state type for the Execute->Memory pipeline register.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_mem_stage_pkg;

    // Default datapath geometry
    localparam int WORD_SIZE_DEF   = 32;
    localparam int REG_ADDR_W_DEF  = 5;
    localparam int MUL_LATENCY_DEF = 4;

    // ALU operation encodings seen on alu_control_e
    localparam logic [2:0] ADD_FUNCT3 = 3'b000;
    localparam logic [2:0] SUB_FUNCT3 = 3'b001;
    localparam logic [2:0] AND_FUNCT3 = 3'b010;
    localparam logic [2:0] OR_FUNCT3  = 3'b011;
    localparam logic [2:0] MUL_FUNCT3 = 3'b100;

    // Writeback mux select encodings
    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_WAIT = 1'b1
    } exm_state_t;

    function automatic logic is_mul_op(input logic [2:0] funct3);
        return (funct3 == MUL_FUNCT3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_counter.sv
// ============================================================================
//  Module  : mul_latency_counter
//  Purpose : Down-counter tracking how many cycles remain before the ALU's
//            internal multiplier presents a valid product.
//  Ports   : clk, rst (async, active-low)
//            i_clr   - force count to zero (highest priority)
//            i_load  - load MUL_LATENCY-1
//            i_dec   - decrement (ignored when already zero)
//            o_cnt   - current count
//            o_zero  - count equals zero
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_latency_counter #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = $clog2(MUL_LATENCY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(MUL_LATENCY - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= C_LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
//  Module  : ex_mem_stage
//  Purpose : Execute->Memory pipeline register. Registers ALU result and
//            control into the M stage, sequences multi-cycle MUL by stalling
//            upstream until the ALU multiplier pipe drains, and supports
//            downstream stall and flush.
//  Ports   : clk, rst (async, active-low)
//            E-stage inputs : valid_e, alu_control_e, alu_out_e, write_data_e,
//                             rd_e, reg_write_e, mem_write_e, result_src_e
//            Control inputs : stall_m, flush_m
//            Outputs        : stall_e, valid_m, alu_result_m, write_data_m,
//                             rd_m, reg_write_m, mem_write_m, result_src_m,
//                             mul_busy, fwd_valid/fwd_rd/fwd_data
//  Config  : EXMEM_FORWARD_EN - when defined, fwd_* taps the M registers;
//            otherwise fwd_* are tied to zero.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_e,
    input  logic [2:0]            alu_control_e,
    input  logic [WORD_SIZE-1:0]  alu_out_e,
    input  logic [WORD_SIZE-1:0]  write_data_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  reg_write_e,
    input  logic                  mem_write_e,
    input  logic [1:0]            result_src_e,
    input  logic                  stall_m,
    input  logic                  flush_m,
    output logic                  stall_e,
    output logic                  valid_m,
    output logic [WORD_SIZE-1:0]  alu_result_m,
    output logic [WORD_SIZE-1:0]  write_data_m,
    output logic [REG_ADDR_W-1:0] rd_m,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
    output logic [1:0]            result_src_m,
    output logic                  mul_busy,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [WORD_SIZE-1:0]  fwd_data
);

    localparam int CNT_W = $clog2(MUL_LATENCY);

    exm_state_t             r_state;
    logic                   r_valid_m;
    logic [WORD_SIZE-1:0]   r_alu_result_m;
    logic [WORD_SIZE-1:0]   r_write_data_m;
    logic [REG_ADDR_W-1:0]  r_rd_m;
    logic                   r_reg_write_m;
    logic                   r_mem_write_m;
    logic [1:0]             r_result_src_m;

    // Control of the MUL currently draining, held until the product retires
    logic [WORD_SIZE-1:0]   r_sh_write_data;
    logic [REG_ADDR_W-1:0]  r_sh_rd;
    logic                   r_sh_reg_write;
    logic                   r_sh_mem_write;
    logic [1:0]             r_sh_result_src;

    logic                   w_is_mul;
    logic                   w_idle;
    logic                   w_wait;
    logic                   w_mul_accept;
    logic                   w_cnt_dec;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_cnt_zero;

    assign w_is_mul     = is_mul_op(alu_control_e);
    assign w_idle       = (r_state == ST_IDLE);
    assign w_wait       = (r_state == ST_MUL_WAIT);
    assign w_mul_accept = w_idle && !stall_m && valid_e && w_is_mul;
    // The ALU multiplier free-runs, so the count drains even under stall_m
    assign w_cnt_dec    = w_wait && !w_cnt_zero;

    mul_latency_counter #(
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mul_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (flush_m),
        .i_load (w_mul_accept),
        .i_dec  (w_cnt_dec),
        .o_cnt  (w_cnt),
        .o_zero (w_cnt_zero)
    );

    // While reset is asserted only the downstream stall propagates upstream,
    // so a MUL sitting in E during reset does not wedge the front end.
    assign stall_e = stall_m
                   | (rst & w_idle & valid_e & w_is_mul)
                   | (rst & w_wait & !w_cnt_zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_valid_m       <= 1'b0;
            r_alu_result_m  <= '0;
            r_write_data_m  <= '0;
            r_rd_m          <= '0;
            r_reg_write_m   <= 1'b0;
            r_mem_write_m   <= 1'b0;
            r_result_src_m  <= '0;
            r_sh_write_data <= '0;
            r_sh_rd         <= '0;
            r_sh_reg_write  <= 1'b0;
            r_sh_mem_write  <= 1'b0;
            r_sh_result_src <= '0;
        end else if (flush_m) begin
            // Flush beats both stall_m and a completing MUL
            r_state       <= ST_IDLE;
            r_valid_m     <= 1'b0;
            r_reg_write_m <= 1'b0;
            r_mem_write_m <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!stall_m) begin
                        if (valid_e && !w_is_mul) begin
                            r_valid_m      <= 1'b1;
                            r_alu_result_m <= alu_out_e;
                            r_write_data_m <= write_data_e;
                            r_rd_m         <= rd_e;
                            r_reg_write_m  <= reg_write_e;
                            r_mem_write_m  <= mem_write_e;
                            r_result_src_m <= result_src_e;
                        end else if (valid_e) begin
                            r_sh_write_data <= write_data_e;
                            r_sh_rd         <= rd_e;
                            r_sh_reg_write  <= reg_write_e;
                            r_sh_mem_write  <= mem_write_e;
                            r_sh_result_src <= result_src_e;
                            r_state         <= ST_MUL_WAIT;
                            r_valid_m       <= 1'b0;
                            r_reg_write_m   <= 1'b0;
                            r_mem_write_m   <= 1'b0;
                        end else begin
                            r_valid_m     <= 1'b0;
                            r_reg_write_m <= 1'b0;
                            r_mem_write_m <= 1'b0;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (!w_cnt_zero) begin
                        r_valid_m     <= 1'b0;
                        r_reg_write_m <= 1'b0;
                        r_mem_write_m <= 1'b0;
                    end else if (!stall_m) begin
                        r_valid_m      <= 1'b1;
                        r_alu_result_m <= alu_out_e;
                        r_write_data_m <= r_sh_write_data;
                        r_rd_m         <= r_sh_rd;
                        r_reg_write_m  <= r_sh_reg_write;
                        r_mem_write_m  <= r_sh_mem_write;
                        r_result_src_m <= r_sh_result_src;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid_m      = r_valid_m;
    assign alu_result_m = r_alu_result_m;
    assign write_data_m = r_write_data_m;
    assign rd_m         = r_rd_m;
    assign reg_write_m  = r_reg_write_m;
    assign mem_write_m  = r_mem_write_m;
    assign result_src_m = r_result_src_m;
    assign mul_busy     = w_wait;

`ifdef EXMEM_FORWARD_EN
    assign fwd_valid = r_valid_m & r_reg_write_m;
    assign fwd_rd    = r_rd_m;
    assign fwd_data  = r_alu_result_m;
`else
    // No forwarding path: the hazard unit must stall on M-stage dependencies
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none

module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e;
    logic [2:0]  alu_control_e;
    logic [31:0] alu_out_e;
    logic [31:0] write_data_e;
    logic [4:0]  rd_e;
    logic        reg_write_e;
    logic        mem_write_e;
    logic [1:0]  result_src_e;
    logic        stall_m;
    logic        flush_m;
    logic        stall_e;
    logic        valid_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [4:0]  rd_m;
    logic        reg_write_m;
    logic        mem_write_m;
    logic [1:0]  result_src_m;
    logic        mul_busy;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .WORD_SIZE   (32),
        .REG_ADDR_W  (5),
        .MUL_LATENCY (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_e       (valid_e),
        .alu_control_e (alu_control_e),
        .alu_out_e     (alu_out_e),
        .write_data_e  (write_data_e),
        .rd_e          (rd_e),
        .reg_write_e   (reg_write_e),
        .mem_write_e   (mem_write_e),
        .result_src_e  (result_src_e),
        .stall_m       (stall_m),
        .flush_m       (flush_m),
        .stall_e       (stall_e),
        .valid_m       (valid_m),
        .alu_result_m  (alu_result_m),
        .write_data_m  (write_data_m),
        .rd_m          (rd_m),
        .reg_write_m   (reg_write_m),
        .mem_write_m   (mem_write_m),
        .result_src_m  (result_src_m),
        .mul_busy      (mul_busy),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns before checking or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                         input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                         input logic mw, input logic [1:0] rs);
        valid_e       = v;
        alu_control_e = op;
        alu_out_e     = res;
        write_data_e  = wd;
        rd_e          = rd;
        reg_write_e   = rw;
        mem_write_e   = mw;
        result_src_e  = rs;
    endtask

    logic        exp_fv;
    logic [4:0]  exp_frd;
    logic [31:0] exp_fdata;

    initial begin
        rst = 1'b0;
        stall_m = 1'b0;
        flush_m = 1'b0;
        drive(1'b0, ADD_FUNCT3, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
        #2;
        check("rst_valid_m", 32'(valid_m), 32'h0);
        check("rst_alu_result", alu_result_m, 32'h0);
        check("rst_stall_e", 32'(stall_e), 32'h0);
        check("rst_mul_busy", 32'(mul_busy), 32'h0);
        step(); step();
        rst = 1'b1;

        // ADD rd=5 -> latency-1 capture
        drive(1'b1, ADD_FUNCT3, 32'h7, 32'hAA, 5'd5, 1'b1, 1'b0, RESULT_SRC_MEM);
        #1;
        check("add_stall_e", 32'(stall_e), 32'h0);
        step();
        drive(1'b0, ADD_FUNCT3, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
        check("add_valid_m", 32'(valid_m), 32'h1);
        check("add_result", alu_result_m, 32'h7);
        check("add_rd", 32'(rd_m), 32'd5);
        check("add_reg_write", 32'(reg_write_m), 32'h1);
        check("add_result_src", 32'(result_src_m), 32'(RESULT_SRC_MEM));
        check("add_write_data", write_data_m, 32'hAA);
        step();
        check("bubble_valid_m", 32'(valid_m), 32'h0);
        check("bubble_reg_write", 32'(reg_write_m), 32'h0);
        check("bubble_hold_result", alu_result_m, 32'h7);

        // MUL rd=9: stall_e high for 4 cycles, retire at T+4 with 0x30
        drive(1'b1, MUL_FUNCT3, 32'h0, 32'h55, 5'd9, 1'b1, 1'b0, RESULT_SRC_ALU);
        #1;
        check("mul_pre_stall_e", 32'(stall_e), 32'h1);
        step();                                   // edge T
        check("mul_T_valid_m", 32'(valid_m), 32'h0);
        check("mul_T_busy", 32'(mul_busy), 32'h1);
        check("mul_T_stall_e", 32'(stall_e), 32'h1);
        step();                                   // T+1
        check("mul_T1_stall_e", 32'(stall_e), 32'h1);
        step();                                   // T+2
        check("mul_T2_stall_e", 32'(stall_e), 32'h1);
        check("mul_T2_valid_m", 32'(valid_m), 32'h0);
        step();                                   // T+3
        alu_out_e = 32'h30;
        check("mul_T3_stall_e", 32'(stall_e), 32'h0);
        check("mul_T3_valid_m", 32'(valid_m), 32'h0);
        check("mul_T3_busy", 32'(mul_busy), 32'h1);
        step();                                   // T+4 retire
        check("mul_ret_valid_m", 32'(valid_m), 32'h1);
        check("mul_ret_result", alu_result_m, 32'h30);
        check("mul_ret_rd", 32'(rd_m), 32'd9);
        check("mul_ret_write_data", write_data_m, 32'h55);
        check("mul_ret_reg_write", 32'(reg_write_m), 32'h1);
        check("mul_ret_busy", 32'(mul_busy), 32'h0);
        drive(1'b0, ADD_FUNCT3, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
        #1;
        check("mul_ret_stall_e", 32'(stall_e), 32'h0);
        step();
        check("mul_after_valid_m", 32'(valid_m), 32'h0);

        // MUL rd=12 with stall_m at cnt==0 for 2 cycles
        drive(1'b1, MUL_FUNCT3, 32'h0, 32'h66, 5'd12, 1'b1, 1'b0, RESULT_SRC_ALU);
        step(); step(); step(); step();           // T..T+3
        alu_out_e = 32'h1234;
        stall_m = 1'b1;
        step();                                   // T+4 held
        check("mstall1_valid_m", 32'(valid_m), 32'h0);
        check("mstall1_busy", 32'(mul_busy), 32'h1);
        check("mstall1_stall_e", 32'(stall_e), 32'h1);
        step();                                   // T+5 held
        check("mstall2_valid_m", 32'(valid_m), 32'h0);
        check("mstall2_busy", 32'(mul_busy), 32'h1);
        stall_m = 1'b0;
        step();                                   // T+6 retire
        check("mstall_ret_valid_m", 32'(valid_m), 32'h1);
        check("mstall_ret_result", alu_result_m, 32'h1234);
        check("mstall_ret_rd", 32'(rd_m), 32'd12);

        // Flush on the MUL completion cycle
        drive(1'b1, MUL_FUNCT3, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, RESULT_SRC_ALU);
        step(); step(); step(); step();           // T..T+3, cnt==0
        alu_out_e = 32'hDEAD;
        flush_m = 1'b1;
        step();
        flush_m = 1'b0;
        drive(1'b0, ADD_FUNCT3, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
        check("flush_valid_m", 32'(valid_m), 32'h0);
        check("flush_busy", 32'(mul_busy), 32'h0);
        check("flush_reg_write", 32'(reg_write_m), 32'h0);
        check("flush_mem_write", 32'(mem_write_m), 32'h0);
        step();
        check("flush_no_late_retire", 32'(valid_m), 32'h0);

        // Async reset mid-MUL_WAIT
        drive(1'b1, MUL_FUNCT3, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, RESULT_SRC_ALU);
        step(); step();
        stall_m = 1'b1;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(mul_busy), 32'h0);
        check("arst_result", alu_result_m, 32'h0);
        check("arst_rd", 32'(rd_m), 32'h0);
        check("arst_stall_e_hi", 32'(stall_e), 32'h1);
        stall_m = 1'b0;
        #1;
        check("arst_stall_e_lo", 32'(stall_e), 32'h0);
        drive(1'b0, ADD_FUNCT3, 32'hBEEF, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
        step();
        rst = 1'b1;
        step(); step(); step(); step();
        check("arst_no_product", 32'(valid_m), 32'h0);

        // ADD rd=3, forwarding tap, then hold under stall_m
        drive(1'b1, ADD_FUNCT3, 32'h99, 32'h0, 5'd3, 1'b1, 1'b0, RESULT_SRC_ALU);
        step();
`ifdef EXMEM_FORWARD_EN
        exp_fv = 1'b1; exp_frd = 5'd3; exp_fdata = 32'h99;
`else
        exp_fv = 1'b0; exp_frd = 5'd0; exp_fdata = 32'h0;
`endif
        check("fwd_valid", 32'(fwd_valid), 32'(exp_fv));
        check("fwd_rd", 32'(fwd_rd), 32'(exp_frd));
        check("fwd_data", fwd_data, exp_fdata);
        stall_m = 1'b1;
        drive(1'b1, OR_FUNCT3, 32'h11, 32'h0, 5'd8, 1'b1, 1'b1, RESULT_SRC_PC4);
        step();
        check("hold_valid_m", 32'(valid_m), 32'h1);
        check("hold_rd", 32'(rd_m), 32'd3);
        check("hold_result", alu_result_m, 32'h99);
        check("hold_mem_write", 32'(mem_write_m), 32'h0);
        stall_m = 1'b0;
        step();
        check("release_rd", 32'(rd_m), 32'd8);
        check("release_mem_write", 32'(mem_write_m), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
